// File: rtl/fdsync_load_arb.sv
`default_nettype none
// ============================================================================
//  Module      : fdsync_load_arb
//  Description : Two-requester arbiter in front of a shared load register.
//                IDLE -> LOAD -> ACK sequence per transfer with a registered
//                load strobe, registered data and a one-cycle ack pulse.
//                A tie is resolved round-robin (FAIR=1) or in favour of
//                requester 0 (FAIR=0).
//  Revision    : 1.0  initial release
// ============================================================================
module fdsync_load_arb #(
   parameter int WIDTH = 32,
   parameter int FAIR  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic [WIDTH-1:0] din0,
   output logic             ack0,
   input  logic             req1,
   input  logic [WIDTH-1:0] din1,
   output logic             ack1,
   output logic             ld,
   output logic [WIDTH-1:0] dout,
   output logic             busy,
   output logic             last
);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_LOAD = 2'd1;
   localparam logic [1:0] c_ACK  = 2'd2;

   logic [1:0]       r_state;
   logic [1:0]       w_next;
   logic             r_win;
   logic             r_last;
   logic             r_ld;
   logic             r_ack0;
   logic             r_ack1;
   logic             r_busy;
   logic [WIDTH-1:0] r_dout;

   logic             w_any;
   logic             w_win_sel;
   logic             w_accept;
   logic             w_ld_nxt;
   logic             w_ack0_nxt;
   logic             w_ack1_nxt;
   logic             w_busy_nxt;

   // Winner selection; only meaningful while IDLE with at least one request.
   always_comb begin
      w_any     = req0 | req1;
      w_win_sel = 1'b0;
      if (req0 && req1) begin
         w_win_sel = (FAIR != 0) ? ~r_last : 1'b0;
      end else begin
         w_win_sel = req1;
      end
   end

   assign w_accept = (r_state == c_IDLE) && w_any;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic: requests are looked at only in IDLE.
   always_comb begin
      w_next = c_IDLE;
      case (r_state)
         c_IDLE:  w_next = w_any ? c_LOAD : c_IDLE;
         c_LOAD:  w_next = c_ACK;
         c_ACK:   w_next = c_IDLE;
         default: w_next = c_IDLE;
      endcase
   end

   // Output decode from the upcoming state so the registered outputs line up
   // with the state they describe.
   always_comb begin
      w_ld_nxt   = (w_next == c_LOAD);
      w_ack0_nxt = (w_next == c_ACK) && !r_win;
      w_ack1_nxt = (w_next == c_ACK) &&  r_win;
      w_busy_nxt = (w_next != c_IDLE);
   end

   // Registered outputs, winner latch, captured data and last-served index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ld   <= 1'b0;
         r_ack0 <= 1'b0;
         r_ack1 <= 1'b0;
         r_busy <= 1'b0;
         r_win  <= 1'b0;
         r_last <= 1'b1;
         r_dout <= '0;
      end else begin
         r_ld   <= w_ld_nxt;
         r_ack0 <= w_ack0_nxt;
         r_ack1 <= w_ack1_nxt;
         r_busy <= w_busy_nxt;
         if (w_accept) begin
            r_win  <= w_win_sel;
            r_dout <= w_win_sel ? din1 : din0;
         end
         if (r_state == c_ACK) begin
            r_last <= r_win;
         end
      end
   end

   assign ld   = r_ld;
   assign ack0 = r_ack0;
   assign ack1 = r_ack1;
   assign busy = r_busy;
   assign last = r_last;
   assign dout = r_dout;

endmodule
`default_nettype wire

// File: doc/fdsync_load_arb.md
FDSYNC_LOAD_ARB -- requirements
Module: fdsync_load_arb

Interface
REQ-001 Parameter: WIDTH, default 32, data width of the shared load register.
REQ-002 Parameter: FAIR, default 1; 1 = round-robin on tie, 0 = fixed priority to requester 0.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: req0  input  1  requester 0 load request, level, held until ack0.
REQ-006 Port: din0  input  WIDTH  requester 0 data, stable while req0 high.
REQ-007 Port: ack0  output  1  one-cycle pulse, requester 0 load done.
REQ-008 Port: req1  input  1  requester 1 load request, level, held until ack1.
REQ-009 Port: din1  input  WIDTH  requester 1 data, stable while req1 high.
REQ-010 Port: ack1  output  1  one-cycle pulse, requester 1 load done.
REQ-011 Port: ld  output  1  load strobe to the shared register's load-enable input.
REQ-012 Port: dout  output  WIDTH  data to the shared register's data input, registered.
REQ-013 Port: busy  output  1  high whenever state is not IDLE.
REQ-014 Port: last  output  1  index of the requester most recently acknowledged.

Function
REQ-015 The block SHALL implement three states: IDLE, LOAD, ACK; all outputs SHALL be registered.
REQ-016 IDLE: no req -> stay IDLE; any req -> LOAD next cycle, winner latched, dout <= winner's din.
REQ-017 Winner selection: only one req -> that one; both with FAIR=1 -> the index not equal to last; both with FAIR=0 -> requester 0.
REQ-018 LOAD: ld SHALL be 1 for exactly this one cycle, dout held; next state ACK.
REQ-019 ACK: ack of the winner SHALL be 1 for exactly this one cycle, the other ack 0; last <= winner; next state IDLE.
REQ-020 Latency: req rising in IDLE at cycle 0 -> ld high in cycle 1 -> ack high in cycle 2 -> IDLE in cycle 3; peak throughput is one load per 3 cycles.
REQ-021 ld and ack0/ack1 SHALL never be high in the same cycle; ack0 and ack1 SHALL never be high together.
REQ-022 dout SHALL change only on the IDLE->LOAD transition; it SHALL hold its value in every other state.
REQ-023 Requests arriving or dropping in LOAD or ACK SHALL be ignored; they are evaluated only in IDLE.
REQ-024 A req still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-025 busy SHALL equal (state != IDLE); last SHALL change only in ACK.

Reset
REQ-026 While rst is high, regardless of clk: state=IDLE, ld=0, ack0=0, ack1=0, busy=0, dout=0, last=1.
REQ-027 Reset asserted during LOAD or ACK SHALL abort the transfer with no ack issued; ld SHALL drop immediately.
REQ-028 After rst falls, the first rising clk edge SHALL evaluate requests from IDLE; with last=1, the first tie goes to requester 0.

Verification
REQ-029 Single request: req0=1, din0=0xDEADBEEF at cycle 0 -> cycle 1 ld=1, dout=0xDEADBEEF; cycle 2 ack0=1; cycle 3 busy=0, last=0.
REQ-030 Tie, FAIR=1: req0 and req1 held high continuously with din0=0x11111111, din1=0x22222222 -> loads alternate 0x11111111, 0x22222222, 0x11111111 on cycles 1, 4, 7; acks alternate ack0, ack1, ack0.
REQ-031 Tie, FAIR=0: same stimulus as REQ-030 -> every load is 0x11111111 and only ack0 pulses while req0 stays high.
REQ-032 Late arrival: req0 at cycle 0, req1 rises at cycle 1 (LOAD) -> req1 is ignored until IDLE at cycle 3; ld for din1 occurs at cycle 4; ack1 occurs at cycle 5.
REQ-033 Reset mid-transfer: req1 at cycle 0; rst pulsed high within cycle 1 -> ld falls asynchronously, no ack1, dout=0, last=1; after rst release with req1 still high -> full load sequence restarts.
REQ-034 Data stability: din0 changed during LOAD and ACK -> dout keeps the value captured at the IDLE->LOAD edge.
